softmax_div_sched: RTL

- Sequencer that normalises a softmax vector by driving the shared 32-bit FP restoring divider.
- For i = 0..len-1: reads exp value x[i] from the exponent buffer, issues x[i] / sum to the divider, and writes the quotient to the output buffer.
- Sits between the exponent/accumulate stage (supplies buffer contents and sum) and the downstream result consumer.
- Owns the divider's start/done handshake, including the required start-release phase between divisions.

---
 rtl/softmax_div_sched.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/softmax_div_sched.sv
// Softmax normaliser sequencer: streams x[i] / sum through the shared FP divider and writes quotients out.
// Optional divider watchdog is compiled in with `define SOFTMAX_DIV_TIMEOUT_EN.
module softmax_div_sched #(
    parameter int N_MAX       = 16,
    parameter int IDX_W       = 4,
    parameter int TIMEOUT_CYC = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_start,
    input  logic [IDX_W:0]   cfg_len,
    input  logic [31:0]      sum_in,
    output logic             busy,
    output logic             done,
    output logic             err_len,
    output logic             err_timeout,
    output logic             rd_en,
    output logic [IDX_W-1:0] rd_addr,
    input  logic [31:0]      rd_data,
    output logic             div_start,
    output logic [31:0]      div_a,
    output logic [31:0]      div_b,
    input  logic             div_done,
    input  logic [31:0]      div_result,
    output logic             wr_en,
    output logic [IDX_W-1:0] wr_addr,
    output logic [31:0]      wr_data
);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        DIV_ISSUE,
        DIV_HOLD,
        DIV_RELEASE,
        WRITE,
        FINISH
    } state_t;

    // An inconsistent parameter set refuses every request rather than addressing out of range.
    localparam bit PARAMS_OK = ((2 ** IDX_W) >= N_MAX) && (N_MAX >= 1) && (TIMEOUT_CYC >= 1);
    localparam logic [IDX_W:0] NMAX_L = (IDX_W + 1)'(N_MAX);
    localparam logic [IDX_W:0] ONE_L  = (IDX_W + 1)'(1);

    state_t           state_q, state_d;
    logic [IDX_W:0]   idx_q, idx_d;
    logic [IDX_W:0]   len_q, len_d;
    logic [31:0]      sum_q, sum_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [31:0]      res_q, res_d;
    logic             start_q, start_d;
    logic             err_len_q, err_len_d;
    logic             len_ok;

`ifdef SOFTMAX_DIV_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0]  wdog_q, wdog_d;
    logic             abort_q, abort_d;
`endif

    assign len_ok = PARAMS_OK && (cfg_len != '0) && (cfg_len <= NMAX_L);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            len_q     <= '0;
            sum_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            start_q   <= 1'b0;
            err_len_q <= 1'b0;
`ifdef SOFTMAX_DIV_TIMEOUT_EN
            wdog_q    <= '0;
            abort_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            sum_q     <= sum_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_q     <= res_d;
            start_q   <= start_d;
            err_len_q <= err_len_d;
`ifdef SOFTMAX_DIV_TIMEOUT_EN
            wdog_q    <= wdog_d;
            abort_q   <= abort_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        len_d     = len_q;
        sum_d     = sum_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        start_d   = start_q;
        err_len_d = 1'b0;
`ifdef SOFTMAX_DIV_TIMEOUT_EN
        wdog_d    = wdog_q;
        abort_d   = abort_q;
`endif
        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    if (len_ok) begin
                        len_d   = cfg_len;
                        sum_d   = sum_in;
                        idx_d   = '0;
                        state_d = RD_REQ;
                    end else begin
                        err_len_d = 1'b1;
                    end
                end
            end
            RD_REQ: begin
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                // Operands are frozen here so they stay stable for the whole start-high window.
                a_d     = rd_data;
                b_d     = sum_q;
                start_d = 1'b1;
                state_d = DIV_ISSUE;
            end
            DIV_ISSUE: begin
                // A done seen here belongs to the previous division and is ignored.
`ifdef SOFTMAX_DIV_TIMEOUT_EN
                wdog_d  = '0;
`endif
                state_d = DIV_HOLD;
            end
            DIV_HOLD: begin
                if (div_done) begin
                    res_d   = div_result;
                    start_d = 1'b0;
                    state_d = DIV_RELEASE;
                end
`ifdef SOFTMAX_DIV_TIMEOUT_EN
                else if (wdog_q == WD_W'(TIMEOUT_CYC - 1)) begin
                    start_d = 1'b0;
                    abort_d = 1'b1;
                    state_d = DIV_RELEASE;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
`endif
            end
            DIV_RELEASE: begin
`ifdef SOFTMAX_DIV_TIMEOUT_EN
                if (abort_q) begin
                    abort_d = 1'b0;
                    state_d = IDLE;
                end else
`endif
                if (!div_done) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (idx_q == (len_q - ONE_L)) begin
                    state_d = FINISH;
                end else begin
                    idx_d   = idx_q + ONE_L;
                    state_d = RD_REQ;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FINISH);
    assign err_len   = err_len_q;
    assign rd_en     = (state_q == RD_REQ);
    assign rd_addr   = rd_en ? idx_q[IDX_W-1:0] : '0;
    assign div_start = start_q;
    assign div_a     = a_q;
    assign div_b     = b_q;
    assign wr_en     = (state_q == WRITE);
    assign wr_addr   = wr_en ? idx_q[IDX_W-1:0] : '0;
    assign wr_data   = wr_en ? res_q : '0;

`ifdef SOFTMAX_DIV_TIMEOUT_EN
    assign err_timeout = (state_q == DIV_RELEASE) && abort_q;
`else
    assign err_timeout = 1'b0;
`endif

endmodule
